// File: rtl/traffic_phase.sv
// Two-way intersection phase controller.
// Moore FSM stepped by a one-per-second tick: NS green/yellow, all-red,
// EW green/yellow, all-red, with a night flashing mode entered only from an
// all-red state so every direction handover is cleared first.
module traffic_phase #(
   parameter int GREEN_T  = 20,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int FLASH_T  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       daynight,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [2:0] phase,
   output logic       night_mode
);

   typedef enum logic [2:0] {
      NS_G      = 3'd0,
      NS_Y      = 3'd1,
      ALL_R1    = 3'd2,
      EW_G      = 3'd3,
      EW_Y      = 3'd4,
      ALL_R2    = 3'd5,
      NIGHT_ON  = 3'd6,
      NIGHT_OFF = 3'd7
   } state_e;

   // Last dwell count of each state; expiry happens on the tick seen at this value.
   localparam logic [7:0] GREEN_LAST  = 8'(GREEN_T  - 1);
   localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
   localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
   localparam logic [7:0] FLASH_LAST  = 8'(FLASH_T  - 1);

   // Light encodings {red, yellow, green}.
   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;
   localparam logic [2:0] L_OFF = 3'b000;

   state_e     state_q, state_d;
   logic [7:0] cnt_q,   cnt_d;
   logic [7:0] last_cnt;
   state_e     next_state;

   // Select the dwell limit and the successor for the current state.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      last_cnt   = ALLRED_LAST;
      next_state = state_q;
      unique case (state_q)
         NS_G:      begin last_cnt = GREEN_LAST;  next_state = NS_Y;   end
         NS_Y:      begin last_cnt = YELLOW_LAST; next_state = ALL_R1; end
         ALL_R1:    begin
            last_cnt   = ALLRED_LAST;
            next_state = daynight ? NIGHT_ON : EW_G;
         end
         EW_G:      begin last_cnt = GREEN_LAST;  next_state = EW_Y;   end
         EW_Y:      begin last_cnt = YELLOW_LAST; next_state = ALL_R2; end
         ALL_R2:    begin
            last_cnt   = ALLRED_LAST;
            next_state = daynight ? NIGHT_ON : NS_G;
         end
         NIGHT_ON:  begin
            last_cnt   = FLASH_LAST;
            next_state = daynight ? NIGHT_OFF : ALL_R2;
         end
         NIGHT_OFF: begin
            last_cnt   = FLASH_LAST;
            next_state = daynight ? NIGHT_ON : ALL_R2;
         end
         default:   begin last_cnt = ALLRED_LAST; next_state = ALL_R2; end
      endcase
   end

   // Advance the dwell counter on each tick; on expiry change state and clear it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tick) begin
         if (cnt_q == last_cnt) begin
            state_d = next_state;
            cnt_d   = 8'd0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // State and counter registers; reset parks in all-red clearance.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= ALL_R2;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Decode lamps purely from the registered state.
   always_comb begin
      ns_light   = L_RED;
      ew_light   = L_RED;
      night_mode = 1'b0;
      unique case (state_q)
         NS_G:      ns_light = L_GRN;
         NS_Y:      ns_light = L_YEL;
         EW_G:      ew_light = L_GRN;
         EW_Y:      ew_light = L_YEL;
         NIGHT_ON:  begin ns_light = L_YEL; night_mode = 1'b1; end
         NIGHT_OFF: begin ns_light = L_OFF; ew_light = L_OFF; night_mode = 1'b1; end
         default:   ;
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase.sv
// Directed bench for traffic_phase: expected per-tick phase/lamp values are
// queued before each run of ticks and compared just before each tick edge.
module tb_traffic_phase;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       daynight;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic [2:0] phase;
   logic       night_mode;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] ph;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       nm;
   } exp_t;

   exp_t sb_q[$];

   traffic_phase #(
      .GREEN_T (5),
      .YELLOW_T(2),
      .ALLRED_T(1),
      .FLASH_T (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .daynight  (daynight),
      .ns_light  (ns_light),
      .ew_light  (ew_light),
      .phase     (phase),
      .night_mode(night_mode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Expected outputs for a phase, taken from the lamp table.
   function automatic exp_t expect_of(input logic [2:0] p);
      exp_t e;
      e.ph = p;
      e.nm = 1'b0;
      e.ns = 3'b100;
      e.ew = 3'b100;
      case (p)
         3'd0: e.ns = 3'b001;
         3'd1: e.ns = 3'b010;
         3'd3: e.ew = 3'b001;
         3'd4: e.ew = 3'b010;
         3'd6: begin e.ns = 3'b010; e.nm = 1'b1; end
         3'd7: begin e.ns = 3'b000; e.ew = 3'b000; e.nm = 1'b1; end
         default: ;
      endcase
      return e;
   endfunction

   // Queue phase p as the expected state for the next n ticks.
   task automatic seg(input logic [2:0] p, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back(expect_of(p));
   endtask

   task automatic compare_now(input exp_t e, input string tag);
      check({tag, ".phase"}, 8'(phase),      8'(e.ph));
      check({tag, ".ns"},    8'(ns_light),   8'(e.ns));
      check({tag, ".ew"},    8'(ew_light),   8'(e.ew));
      check({tag, ".night"}, 8'(night_mode), 8'(e.nm));
   endtask

   // Issue n ticks; before each, pop and compare the expected current state.
   // spaced=1 gives one tick every 4 clks, spaced=0 holds tick high.
   task automatic run(input int n, input bit spaced, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b0;
         if (spaced) repeat (3) @(negedge clk);
         if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 8'd1, 8'd0);
         end else begin
            e = sb_q.pop_front();
            compare_now(e, tag);
         end
         tick = 1'b1;
      end
      @(negedge clk);
      tick = 1'b0;
   endtask

   // Safety: never green/yellow on both approaches at once.
   always @(negedge clk) begin
      if (ns_light !== 3'b100 && ew_light !== 3'b100 &&
          ns_light !== 3'b000 && ew_light !== 3'b000) begin
         checks++;
         errors++;
         $error("FAIL conflict: ns %b ew %b both not red", ns_light, ew_light);
      end
   end

   initial begin
      rst      = 1'b1;
      tick     = 1'b0;
      daynight = 1'b0;
      #2;
      compare_now(expect_of(3'd5), "reset");
      @(negedge clk);
      rst = 1'b0;

      // Full day cycle: 16 ticks, then back to NS_G.
      seg(3'd5, 1); seg(3'd0, 5); seg(3'd1, 2); seg(3'd2, 1);
      seg(3'd3, 5); seg(3'd4, 2); seg(3'd5, 1);
      run(17, 1'b1, "day");

      // Night request raised mid EW_G: EW side completes, then night flash.
      seg(3'd0, 5); seg(3'd1, 2); seg(3'd2, 1); seg(3'd3, 2);
      run(10, 1'b1, "to_ewg");
      daynight = 1'b1;
      seg(3'd3, 3); seg(3'd4, 2); seg(3'd5, 1);
      run(6, 1'b1, "ewg_hold");
      seg(3'd6, 1); seg(3'd7, 1); seg(3'd6, 1); seg(3'd7, 1);
      seg(3'd6, 1);
      run(5, 1'b1, "flash");

      // Day returns during NIGHT_OFF: one all-red tick then NS_G.
      daynight = 1'b0;
      seg(3'd7, 1); seg(3'd5, 1); seg(3'd0, 1);
      run(3, 1'b1, "night_exit");

      // Night request sampled at ALL_R1 expiry.
      seg(3'd0, 4); seg(3'd1, 2);
      run(6, 1'b1, "to_allr1");
      daynight = 1'b1;
      seg(3'd2, 1);
      run(1, 1'b1, "allr1_night");
      daynight = 1'b0;
      seg(3'd6, 1); seg(3'd5, 1); seg(3'd0, 1);
      run(3, 1'b1, "night_exit2");

      // Short reset pulse in NS_G with counter at 3.
      seg(3'd0, 2);
      run(2, 1'b1, "pre_rst");
      #1 rst = 1'b1;
      #1 compare_now(expect_of(3'd5), "rst_pulse");
      #1 rst = 1'b0;
      seg(3'd5, 1); seg(3'd0, 5); seg(3'd1, 1);
      run(7, 1'b1, "post_rst");

      // No ticks for 1000 clks: nothing moves.
      repeat (1000) @(negedge clk);
      compare_now(expect_of(3'd1), "idle");
      seg(3'd1, 1); seg(3'd2, 1);
      run(2, 1'b1, "after_idle");

      // Tick held high: one count per clk edge.
      seg(3'd3, 5); seg(3'd4, 2); seg(3'd5, 1); seg(3'd0, 1);
      run(9, 1'b0, "held");
      repeat (2) @(negedge clk);
      compare_now(expect_of(3'd0), "held_end");

      check("sb_left", 8'(sb_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_phase.md
TRAFFIC_PHASE -- requirements
Module: traffic_phase

Interface
REQ-001 Parameter GREEN_T, default 20, green duration in ticks (1..255).
REQ-002 Parameter YELLOW_T, default 3, yellow duration in ticks (1..255).
REQ-003 Parameter ALLRED_T, default 2, all-red clearance duration in ticks (1..255).
REQ-004 Parameter FLASH_T, default 1, night flash half-period in ticks (1..255).
REQ-005 Ports SHALL be, clock and reset first:
  clk  input  1  single system clock; all logic on rising edge.
  rst  input  1  asynchronous, active-high reset.
  tick  input  1  one-clk pulse per second; time base.
  daynight  input  1  0 = day, 1 = night; produced by the hour-based day/night detector.
  ns_light  output  3  {red, yellow, green} for north-south heads.
  ew_light  output  3  {red, yellow, green} for east-west heads.
  phase  output  3  current state encoding, per REQ-008.
  night_mode  output  1  1 while in NIGHT_ON or NIGHT_OFF.

Function
REQ-006 The block SHALL be a Moore FSM; all outputs decode from the registered state only, with no combinational path from any input.
REQ-007 An 8-bit dwell counter SHALL increment only on clk edges with tick=1 and SHALL clear to 0 on every state change.
REQ-008 States and encodings SHALL be: NS_G=0, NS_Y=1, ALL_R1=2, EW_G=3, EW_Y=4, ALL_R2=5, NIGHT_ON=6, NIGHT_OFF=7.
REQ-009 A state SHALL expire on the clk edge where tick=1 and the counter equals its duration minus 1; no state change occurs on any other edge.
REQ-010 Day sequence on expiry: NS_G(GREEN_T) -> NS_Y(YELLOW_T) -> ALL_R1(ALLRED_T) -> EW_G(GREEN_T) -> EW_Y(YELLOW_T) -> ALL_R2(ALLRED_T) -> NS_G.
REQ-011 daynight SHALL be sampled only at expiry of ALL_R1 or ALL_R2; if 1, next state is NIGHT_ON instead of EW_G or NS_G.
REQ-012 A daynight change during NS_G, NS_Y, EW_G or EW_Y SHALL NOT shorten or alter that state; the change takes effect at the next all-red expiry.
REQ-013 NIGHT_ON and NIGHT_OFF SHALL alternate on expiry, each lasting FLASH_T ticks, while daynight=1.
REQ-014 If daynight=0 at expiry of NIGHT_ON or NIGHT_OFF, next state SHALL be ALL_R2, giving a full ALLRED_T clearance before NS_G.
REQ-015 Light decode: NS_G ns=001 ew=100; NS_Y ns=010 ew=100; EW_G ns=100 ew=001; EW_Y ns=100 ew=010; ALL_R1/ALL_R2 ns=100 ew=100; NIGHT_ON ns=010 ew=100; NIGHT_OFF ns=000 ew=000.
REQ-016 No state SHALL ever give green or yellow to both directions simultaneously; every NS to EW or EW to NS handover SHALL pass through an all-red state.
REQ-017 Counter SHALL never wrap; it is cleared at expiry, so value never exceeds 254.
REQ-018 tick held high on consecutive clks SHALL count once per clk edge, with no edge detection.

Reset
REQ-019 While rst=1: state=ALL_R2, counter=0, ns_light=100, ew_light=100, phase=5, night_mode=0, asynchronously, without waiting for clk.
REQ-020 Reset asserted mid-state SHALL abort that state immediately; after release the full ALLRED_T clearance runs before any green.
REQ-021 The first counted tick SHALL be the first tick=1 on a clk edge after rst deasserts.

Verification (GREEN_T=5, YELLOW_T=2, ALLRED_T=1, FLASH_T=1 unless noted)
REQ-022 Reset, daynight=0, tick every 4 clks -> phase 5,0(5 ticks),1(2),2(1),3(5),4(2),5(1),0; ns/ew per REQ-015 at each step; one full cycle = 16 ticks.
REQ-023 daynight 0->1 during EW_G -> EW_G runs full 5 ticks, EW_Y 2, ALL_R2 1, then phase 6; night_mode=1; ns_light toggles 010/000 each tick.
REQ-024 daynight 1->0 during NIGHT_OFF -> at that state's expiry phase=5 for 1 tick, all lights 100, then phase 0 with ns_light=001; night_mode=0 from the ALL_R2 entry edge.
REQ-025 rst pulse asserted mid-NS_G at counter=3, shorter than one clk period -> outputs show 100/100 and phase=5 during the pulse; after release, 1 tick later phase=0 with counter restarted at 0.
REQ-026 tick=0 held for 1000 clks in any state -> no state or output change; assertion check over all runs: never (ns_light!=100 && ew_light!=100 && neither is 000).
